mem_stage_ext: RTL and testbench
================================

Name: mem_stage_ext

Overview:
- Parametrised successor of the pipeline memory stage.
- Sits between EX and WB. Accepts an EX-issued data-SRAM request tagged in the EX-to-MEM bus and waits for the request's data_ok on a request/response (SRAM-like) interface.
- Performs sub-word load alignment and extension: LB/LBU/LH/LHU/LW/LWL/LWR.
- Buffers a returned word when WB stalls, and exports forwarding/stall info to ID, including whether the MEM result is ready yet.

Parameters:
- XLEN, 32, data/address width; power of two, 32 or 64 (64 uses bits [2:0] for byte lane, word ops on low 32 sign-extended).
- REG_AW, 5, register index width.
- LOP_W, 3, load-op code width.
- ES_TO_MS_BUS_WD, LOP_W+3+REG_AW+3*XLEN, EX-to-MEM bus width (derived; do not override).
- MS_TO_WS_BUS_WD, 1+REG_AW+2*XLEN, MEM-to-WB bus width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- es_to_ms_valid  in  1  EX holds a valid instruction
- es_to_ms_bus  in  ES_TO_MS_BUS_WD  MSB to LSB: {load_op, req_sent, res_from_mem, gr_we, dest, rt_value, alu_result, pc}
- ms_allowin  out  1  MEM can accept this cycle
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  result valid to WB
- ms_to_ws_bus  out  MS_TO_WS_BUS_WD  {gr_we, dest, final_result, pc}
- data_sram_data_ok  in  1  one-cycle pulse: read/write response for oldest outstanding request
- data_sram_rdata  in  XLEN  valid when data_ok=1
- ms_write_reg  out  1  gr_we && ms_valid
- ms_reg_dest  out  REG_AW  destination register
- ms_res_ready  out  1  final_result valid this cycle (0 while a load waits); ID stalls on RAW hit when 0
- ms_to_ds_bus  out  XLEN  forwarded final_result

Behaviour:
- Reset (synchronous): ms_valid=0, state=IDLE, rdata buffer=0, es_to_ms_bus_r=0. Consequently ms_to_ws_valid=0, ms_write_reg=0, ms_res_ready=0.
- A data_ok in the reset cycle is discarded. The SRAM is reset in the same cycle, so no stale response follows.
- Accept: when es_to_ms_valid && ms_allowin, register the bus using nonblocking assignment. ms_valid<=es_to_ms_valid whenever ms_allowin.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- State machine:
  - IDLE: entered on accept. If req_sent=1 go to WAIT, else go to/stay READY.
  - WAIT: data_ok=1 captures rdata into the buffer and moves to READY in the same edge.
  - READY: holds the buffered data until the handoff to WB.
  - On handoff (ms_to_ws_valid && ws_allowin): next state depends on the newly accepted instruction, or IDLE if none.
- req_sent=1 covers stores too. A store also waits for data_ok, with rdata ignored.
- data_ok may arrive in the first cycle after accept at the earliest. ms_ready_go = (state==READY) || (state==WAIT && data_ok).
  - Zero-bubble: data_ok with ws_allowin=1 hands off the same cycle, using rdata directly (bypassing the buffer).
- data_ok while ms_valid=0 or state!=WAIT is a protocol error. Ignore it; the assertion bench flags it.
- Load alignment, with off = alu_result[1:0] (XLEN=32) and byte lane from off:
  - LB/LBU: byte at off, sign/zero-extended.
  - LH/LHU: halfword at off[1], extended. off[0]=1 is not checked here (AdEL is raised upstream).
  - LW: full word.
  - LWL: merge high bytes of rdata<<(8*(3-off)) over rt_value's low (3-off) bytes.
  - LWR: rdata>>(8*off) into low (4-off) bytes, keeping rt_value's high bytes.
- final_result = res_from_mem ? aligned_load : alu_result.
- ms_res_ready = ms_valid && (!res_from_mem || ms_ready_go).
- Forwarding outputs are combinational from registered state plus data_ok. There is no combinational path from ws_allowin to ms_res_ready.

Decomposition:
- Shared package/header `mycpu.h`:
  - LOP_* codes: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6.
  - ES_TO_MS/MS_TO_WS width macros and field offsets.
- One sub-module: load_align (combinational: load_op, off, rdata, rt_value -> result). It is unit-testable in isolation.

Test Plan:
- LW at 0x100, data_ok 2 cycles after accept, rdata=0x8899AABB, ws_allowin=1 -> ms_res_ready=0 for 1 cycle, then ms_to_ws_valid=1 with result 0x8899AABB in the data_ok cycle.
- LB off=3 rdata=0x80112233 -> 0xFFFFFF80. LBU -> 0x00000080. LH off=2 -> 0xFFFF8011. LHU -> 0x00008011.
- LWL off=1, rt=0x11223344, rdata=0xAABBCCDD -> 0xCCDD3344. LWR off=1 same inputs -> 0x11AABBCC.
- data_ok=1 with ws_allowin=0 for 3 cycles -> state READY, result held stable, ms_allowin=0. On release -> single handoff with the buffered data.
- Back-to-back ALU ops with ws_allowin=1 -> one result per cycle, ms_res_ready=1 each cycle, no bubbles.
- Reset asserted in WAIT with data_ok in the same cycle -> next cycle ms_valid=0, state IDLE, no WB write.

Source files
------------

// File: rtl/mem_stage_ext_pkg.sv
// Shared definitions for the memory pipeline stage: load-op codes, stage
// states and the derived EX->MEM / MEM->WB bus widths.
package mem_stage_ext_pkg;

  localparam logic [2:0] LOP_LB  = 3'd0;
  localparam logic [2:0] LOP_LBU = 3'd1;
  localparam logic [2:0] LOP_LH  = 3'd2;
  localparam logic [2:0] LOP_LHU = 3'd3;
  localparam logic [2:0] LOP_LW  = 3'd4;
  localparam logic [2:0] LOP_LWL = 3'd5;
  localparam logic [2:0] LOP_LWR = 3'd6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  // {load_op, req_sent, res_from_mem, gr_we, dest, rt_value, alu_result, pc}
  function automatic int es_to_ms_bus_wd(input int xlen, input int reg_aw, input int lop_w);
    return lop_w + 3 + reg_aw + 3 * xlen;
  endfunction

  // {gr_we, dest, final_result, pc}
  function automatic int ms_to_ws_bus_wd(input int xlen, input int reg_aw);
    return 1 + reg_aw + 2 * xlen;
  endfunction

endpackage

// File: rtl/mem_stage_ext_if.sv
// Pipeline-side signals of the memory stage: EX handshake, WB handshake,
// data-SRAM response and the forwarding info exported to ID.
interface mem_stage_ext_if
  import mem_stage_ext_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int LOP_W  = 3
);
  localparam int ES_TO_MS_BUS_WD = es_to_ms_bus_wd(XLEN, REG_AW, LOP_W);
  localparam int MS_TO_WS_BUS_WD = ms_to_ws_bus_wd(XLEN, REG_AW);

  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       data_sram_data_ok;
  logic [XLEN-1:0]            data_sram_rdata;
  logic                       ms_write_reg;
  logic [REG_AW-1:0]          ms_reg_dest;
  logic                       ms_res_ready;
  logic [XLEN-1:0]            ms_to_ds_bus;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_write_reg, ms_reg_dest,
           ms_res_ready, ms_to_ds_bus
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_write_reg, ms_reg_dest,
           ms_res_ready, ms_to_ds_bus
  );

endinterface

// File: rtl/mem_stage_ext_load_align.sv
// Combinational sub-word load alignment and extension (LB..LWR). Word ops
// act on the 32-bit lane selected by the address and are sign-extended.
module mem_stage_ext_load_align
  import mem_stage_ext_pkg::*;
#(
  parameter int  XLEN  = 32,
  parameter int  LOP_W = 3,
  localparam int OW    = $clog2(XLEN / 8)
) (
  input  logic [LOP_W-1:0] load_op,
  input  logic [OW-1:0]    off,
  input  logic [XLEN-1:0]  rdata,
  input  logic [XLEN-1:0]  rt_value,
  output logic [XLEN-1:0]  result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;
  logic [31:0] rt_word;
  logic [1:0]  woff;
  logic [31:0] lwl_word;
  logic [31:0] lwr_word;

  assign byte_sel = rdata[8 * int'(off) +: 8];
  assign half_sel = rdata[16 * (int'(off) >> 1) +: 16];
  assign word_sel = rdata[32 * (int'(off) >> 2) +: 32];
  assign rt_word  = rt_value[31:0];
  assign woff     = off[1:0];

  // LWL fills the top bytes from memory, LWR the bottom bytes; the rest keeps rt.
  assign lwl_word = (word_sel << (8 * (3 - int'(woff))))
                  | (rt_word & (32'hFFFF_FFFF >> (8 * (int'(woff) + 1))));
  assign lwr_word = (word_sel >> (8 * int'(woff)))
                  | (rt_word & ~(32'hFFFF_FFFF >> (8 * int'(woff))));

  // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    result = '0;
    case (load_op)
      LOP_W'(LOP_LB):  result = XLEN'($signed(byte_sel));
      LOP_W'(LOP_LBU): result = XLEN'(byte_sel);
      LOP_W'(LOP_LH):  result = XLEN'($signed(half_sel));
      LOP_W'(LOP_LHU): result = XLEN'(half_sel);
      LOP_W'(LOP_LW):  result = XLEN'($signed(word_sel));
      LOP_W'(LOP_LWL): result = XLEN'($signed(lwl_word));
      LOP_W'(LOP_LWR): result = XLEN'($signed(lwr_word));
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_ext.sv
// Pipeline memory stage: holds one instruction between EX and WB, waits for
// its data-SRAM response, aligns loads and exports forwarding info to ID.
module mem_stage_ext
  import mem_stage_ext_pkg::*;
#(
  parameter int  XLEN            = 32,
  parameter int  REG_AW          = 5,
  parameter int  LOP_W           = 3,
  localparam int ES_TO_MS_BUS_WD = es_to_ms_bus_wd(XLEN, REG_AW, LOP_W),
  localparam int MS_TO_WS_BUS_WD = ms_to_ws_bus_wd(XLEN, REG_AW)
) (
  input logic           clk,
  input logic           reset,
  mem_stage_ext_if.slave bus
);

  localparam int OW = $clog2(XLEN / 8);

  logic                       ms_valid;
  logic [1:0]                 state;
  logic [XLEN-1:0]            rdata_buf;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;

  logic [LOP_W-1:0]  load_op;
  logic              req_sent;
  logic              res_from_mem;
  logic              gr_we;
  logic [REG_AW-1:0] dest;
  logic [XLEN-1:0]   rt_value;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   pc;

  logic              in_req_sent;
  logic              resp_now;
  logic              ms_ready_go;
  logic [XLEN-1:0]   mem_word;
  logic [XLEN-1:0]   aligned;
  logic [XLEN-1:0]   final_result;
  logic              unused_req_sent;

  assign {load_op, req_sent, res_from_mem, gr_we, dest, rt_value, alu_result, pc} = es_to_ms_bus_r;
  // The WAIT state already encodes an outstanding request, so the stored flag is informational.
  assign unused_req_sent = req_sent;

  assign in_req_sent = bus.es_to_ms_bus[ES_TO_MS_BUS_WD-LOP_W-1];
  assign resp_now    = (state == S_WAIT) && bus.data_sram_data_ok;
  assign ms_ready_go = (state == S_READY) || resp_now;
  assign bus.ms_allowin = !ms_valid || (ms_ready_go && bus.ws_allowin);

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid       <= 1'b0;
      state          <= S_IDLE;
      rdata_buf      <= '0;
      es_to_ms_bus_r <= '0;
    end else begin
      if (bus.ms_allowin) begin
        ms_valid <= bus.es_to_ms_valid;
      end
      if (bus.es_to_ms_valid && bus.ms_allowin) begin
        es_to_ms_bus_r <= bus.es_to_ms_bus;
      end
      if (bus.ms_allowin) begin
        state <= !bus.es_to_ms_valid ? S_IDLE : (in_req_sent ? S_WAIT : S_READY);
      end else if (resp_now) begin
        state     <= S_READY;
        rdata_buf <= bus.data_sram_rdata;
      end
    end
  end

  // Zero-bubble handoff reads the response directly instead of the buffer.
  assign mem_word = (state == S_WAIT) ? bus.data_sram_rdata : rdata_buf;

  mem_stage_ext_load_align #(
    .XLEN  (XLEN),
    .LOP_W (LOP_W)
  ) u_load_align (
    .load_op  (load_op),
    .off      (alu_result[OW-1:0]),
    .rdata    (mem_word),
    .rt_value (rt_value),
    .result   (aligned)
  );

  assign final_result = res_from_mem ? aligned : alu_result;

  assign bus.ms_to_ws_valid = ms_valid && ms_ready_go;
  assign bus.ms_to_ws_bus   = MS_TO_WS_BUS_WD'({gr_we, dest, final_result, pc});
  assign bus.ms_write_reg   = gr_we && ms_valid;
  assign bus.ms_reg_dest    = dest;
  assign bus.ms_res_ready   = ms_valid && (!res_from_mem || ms_ready_go);
  assign bus.ms_to_ds_bus   = final_result;

endmodule

// File: tb/tb_mem_stage_ext.sv
// Directed plus randomized bench for mem_stage_ext against a byte-level
// reference model of the load rules and the stage handshake.
module tb_mem_stage_ext;
  import mem_stage_ext_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_stage_ext_if #(.XLEN(32), .REG_AW(5), .LOP_W(3)) ms_if ();

  mem_stage_ext #(.XLEN(32), .REG_AW(5), .LOP_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ms_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-oriented model of the load rules, little-endian lanes.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] rd, input logic [31:0] rt);
    logic [7:0] b [4];
    logic [7:0] r [4];
    logic [7:0] o [4];
    int k;
    int h;
    k = int'(off);
    h = off[1] ? 2 : 0;
    for (int i = 0; i < 4; i++) begin
      b[i] = rd[8*i +: 8];
      r[i] = rt[8*i +: 8];
    end
    case (op)
      LOP_LB:  return {{24{b[k][7]}}, b[k]};
      LOP_LBU: return {24'h0, b[k]};
      LOP_LH:  return {{16{b[h+1][7]}}, b[h+1], b[h]};
      LOP_LHU: return {16'h0, b[h+1], b[h]};
      LOP_LW:  return rd;
      LOP_LWL: begin
        for (int i = 0; i < 4; i++) o[i] = (i >= 3 - k) ? b[i-(3-k)] : r[i];
        return {o[3], o[2], o[1], o[0]};
      end
      LOP_LWR: begin
        for (int i = 0; i < 4; i++) o[i] = (i <= 3 - k) ? b[i+k] : r[i];
        return {o[3], o[2], o[1], o[0]};
      end
      default: return 32'h0;
    endcase
  endfunction

  // Issue one instruction into an empty stage, deliver data_ok after dly cycles
  // (if a request was sent), hold WB off for stall cycles, then hand off.
  task automatic run_instr(input string name, input logic [2:0] op, input logic req,
                           input logic rfm, input logic we, input logic [4:0] dest,
                           input logic [31:0] rt, input logic [31:0] alu,
                           input logic [31:0] pc, input logic [31:0] rdata,
                           input int dly, input int stall);
    logic [31:0] exp_res;
    logic [69:0] exp_bus;
    exp_res = rfm ? ref_load(op, alu[1:0], rdata, rt) : alu;
    exp_bus = {we, dest, exp_res, pc};

    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = {op, req, rfm, we, dest, rt, alu, pc};
    ms_if.ws_allowin     = 1'b1;
    settle();
    check({name, "_accept_allowin"}, 128'(ms_if.ms_allowin), 128'(1'b1));
    step();
    ms_if.es_to_ms_valid = 1'b0;
    ms_if.es_to_ms_bus   = {$urandom, $urandom, $urandom, $urandom};

    if (req) begin
      for (int i = 1; i < dly; i++) begin
        settle();
        check({name, "_wait_valid"}, 128'(ms_if.ms_to_ws_valid), 128'(1'b0));
        check({name, "_wait_res_ready"}, 128'(ms_if.ms_res_ready), 128'(!rfm));
        check({name, "_wait_write_reg"}, 128'(ms_if.ms_write_reg), 128'(we));
        check({name, "_wait_allowin"}, 128'(ms_if.ms_allowin), 128'(1'b0));
        step();
      end
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = rdata;
    end

    for (int i = 0; i < stall; i++) begin
      ms_if.ws_allowin = 1'b0;
      settle();
      check({name, "_stall_valid"}, 128'(ms_if.ms_to_ws_valid), 128'(1'b1));
      check({name, "_stall_res_ready"}, 128'(ms_if.ms_res_ready), 128'(1'b1));
      check({name, "_stall_allowin"}, 128'(ms_if.ms_allowin), 128'(1'b0));
      check({name, "_stall_fwd"}, 128'(ms_if.ms_to_ds_bus), 128'(exp_res));
      step();
      ms_if.data_sram_data_ok = 1'b0;
      ms_if.data_sram_rdata   = $urandom;
    end

    ms_if.ws_allowin = 1'b1;
    settle();
    check({name, "_out_valid"}, 128'(ms_if.ms_to_ws_valid), 128'(1'b1));
    check({name, "_out_bus"}, 128'(ms_if.ms_to_ws_bus), 128'(exp_bus));
    check({name, "_out_res_ready"}, 128'(ms_if.ms_res_ready), 128'(1'b1));
    check({name, "_out_dest"}, 128'(ms_if.ms_reg_dest), 128'(dest));
    step();
    ms_if.data_sram_data_ok = 1'b0;
    settle();
    check({name, "_after_valid"}, 128'(ms_if.ms_to_ws_valid), 128'(1'b0));
    check({name, "_after_allowin"}, 128'(ms_if.ms_allowin), 128'(1'b1));
  endtask

  initial begin
    logic [31:0] alu_q [$];
    logic [31:0] pc_q [$];
    logic [4:0]  dst_q [$];
    logic [31:0] a;
    logic [31:0] p;
    logic [4:0]  d;
    int kind;

    reset                   = 1'b1;
    ms_if.es_to_ms_valid    = 1'b0;
    ms_if.es_to_ms_bus      = '0;
    ms_if.ws_allowin        = 1'b1;
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = '0;
    step();
    step();
    check("rst_valid", 128'(ms_if.ms_to_ws_valid), 128'(1'b0));
    check("rst_write_reg", 128'(ms_if.ms_write_reg), 128'(1'b0));
    check("rst_res_ready", 128'(ms_if.ms_res_ready), 128'(1'b0));
    reset = 1'b0;
    step();
    check("idle_allowin", 128'(ms_if.ms_allowin), 128'(1'b1));

    // LW with data_ok two cycles after accept, zero-bubble handoff
    run_instr("lw", LOP_LW, 1'b1, 1'b1, 1'b1, 5'd5, 32'h0, 32'h100, 32'hBFC0_0000,
              32'h8899_AABB, 2, 0);
    run_instr("lb", LOP_LB, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0, 32'h203, 32'hBFC0_0004,
              32'h8011_2233, 1, 0);
    run_instr("lbu", LOP_LBU, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 32'h203, 32'hBFC0_0008,
              32'h8011_2233, 1, 0);
    run_instr("lh", LOP_LH, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0, 32'h202, 32'hBFC0_000C,
              32'h8011_2233, 1, 0);
    run_instr("lhu", LOP_LHU, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0, 32'h202, 32'hBFC0_0010,
              32'h8011_2233, 1, 0);
    run_instr("lwl", LOP_LWL, 1'b1, 1'b1, 1'b1, 5'd10, 32'h1122_3344, 32'h301,
              32'hBFC0_0014, 32'hAABB_CCDD, 1, 0);
    run_instr("lwr", LOP_LWR, 1'b1, 1'b1, 1'b1, 5'd11, 32'h1122_3344, 32'h301,
              32'hBFC0_0018, 32'hAABB_CCDD, 1, 0);
    // WB stalled for three cycles starting in the data_ok cycle
    run_instr("stall", LOP_LW, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0, 32'h400, 32'hBFC0_001C,
              32'hDEAD_BEEF, 1, 3);

    // Back-to-back ALU ops: one result per cycle, no bubbles
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        a = $urandom;
        p = $urandom;
        d = 5'($urandom_range(1, 31));
        alu_q.push_back(a);
        pc_q.push_back(p);
        dst_q.push_back(d);
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus   = {LOP_LW, 1'b0, 1'b0, 1'b1, d, 32'($urandom), a, p};
      end else begin
        ms_if.es_to_ms_valid = 1'b0;
      end
      settle();
      check("b2b_allowin", 128'(ms_if.ms_allowin), 128'(1'b1));
      if (k > 0) begin
        a = alu_q.pop_front();
        p = pc_q.pop_front();
        d = dst_q.pop_front();
        check("b2b_valid", 128'(ms_if.ms_to_ws_valid), 128'(1'b1));
        check("b2b_res_ready", 128'(ms_if.ms_res_ready), 128'(1'b1));
        check("b2b_bus", 128'(ms_if.ms_to_ws_bus), 128'({1'b1, d, a, p}));
      end
      step();
    end
    settle();
    check("b2b_drained", 128'(ms_if.ms_to_ws_valid), 128'(1'b0));

    // Reset while waiting with a data_ok in the reset cycle
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = {LOP_LW, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0, 32'h500, 32'hBFC0_0100};
    step();
    ms_if.es_to_ms_valid    = 1'b0;
    reset                   = 1'b1;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h1234_5678;
    step();
    reset                   = 1'b0;
    ms_if.data_sram_data_ok = 1'b0;
    settle();
    check("rstwait_valid", 128'(ms_if.ms_to_ws_valid), 128'(1'b0));
    check("rstwait_write_reg", 128'(ms_if.ms_write_reg), 128'(1'b0));
    check("rstwait_res_ready", 128'(ms_if.ms_res_ready), 128'(1'b0));
    check("rstwait_allowin", 128'(ms_if.ms_allowin), 128'(1'b1));
    step();

    // Randomized mix of ALU ops, loads and stores
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0: run_instr("rnd_alu", 3'($urandom_range(0, 6)), 1'b0, 1'b0, 1'b1,
                     5'($urandom), $urandom, $urandom, $urandom, $urandom,
                     1, $urandom_range(0, 2));
        1: run_instr("rnd_load", 3'($urandom_range(0, 6)), 1'b1, 1'b1, 1'b1,
                     5'($urandom), $urandom, $urandom, $urandom, $urandom,
                     $urandom_range(1, 3), $urandom_range(0, 2));
        default: run_instr("rnd_store", 3'($urandom_range(0, 6)), 1'b1, 1'b0, 1'b0,
                           5'($urandom), $urandom, $urandom, $urandom, $urandom,
                           $urandom_range(1, 3), $urandom_range(0, 2));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
